// File: rtl/dct2d_rowcol_sched.sv
// dct2d_rowcol_sched: row/column sequencer for an 8x8 2-D DCT that time-shares one 8-point 1-D DCT core
// Pass 1 streams input rows through the core into a transpose buffer; pass 2 streams buffer columns out.
module dct2d_rowcol_sched #(
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [8*DATA_W-1:0] s_data,
   output logic                dct_in_valid,
   input  logic                dct_in_ready,
   output logic [8*DATA_W-1:0] dct_in_data,
   input  logic                dct_out_valid,
   output logic                dct_out_ready,
   input  logic [8*DATA_W-1:0] dct_out_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [8*DATA_W-1:0] m_data,
   output logic                m_last,
   output logic                busy,
   output logic                blk_done
);

   typedef enum logic [1:0] {IDLE, ROW, COL} state_t;

   state_t              state, state_nxt;
   logic [3:0]          iss_cnt, iss_nxt, rcv_cnt, rcv_nxt;
   logic                done_nxt, iss_open, rcv_last;
   logic [DATA_W-1:0]   tbuf [8][8];
   logic [8*DATA_W-1:0] col_data;

   assign iss_open    = iss_cnt < 4'd8;
   assign rcv_last    = rcv_cnt == 4'd7;
   assign busy        = state != IDLE;
   assign m_data      = dct_out_data;
   assign dct_in_data = state == COL ? col_data : s_data;

   // Column read of the transpose buffer: element k comes from buffer row k.
   always_comb begin
      col_data = '0;
      for (int k = 0; k < 8; k++) col_data[k*DATA_W +: DATA_W] = tbuf[k][iss_cnt[2:0]];
   end

   always_comb begin
      state_nxt     = state;
      iss_nxt       = iss_cnt;
      rcv_nxt       = rcv_cnt;
      done_nxt      = 1'b0;
      s_ready       = 1'b0;
      dct_in_valid  = 1'b0;
      dct_out_ready = 1'b0;
      m_valid       = 1'b0;
      m_last        = 1'b0;
      case (state)
         IDLE: begin
            if (s_valid) begin
               state_nxt = ROW;
               iss_nxt   = '0;
               rcv_nxt   = '0;
            end
         end
         ROW: begin
            s_ready       = dct_in_ready && iss_open;
            dct_in_valid  = s_valid && iss_open;
            dct_out_ready = 1'b1;
            if (s_valid && s_ready) iss_nxt = iss_cnt + 4'd1;
            if (dct_out_valid) rcv_nxt = rcv_cnt + 4'd1;
            // The in-order core guarantees all row results are back once the 8th is captured.
            if (dct_out_valid && rcv_last) begin
               state_nxt = COL;
               iss_nxt   = '0;
               rcv_nxt   = '0;
            end
         end
         COL: begin
            dct_in_valid  = iss_open;
            m_valid       = dct_out_valid;
            dct_out_ready = m_ready;
            m_last        = dct_out_valid && rcv_last;
            if (dct_in_ready && iss_open) iss_nxt = iss_cnt + 4'd1;
            if (dct_out_valid && m_ready) begin
               rcv_nxt = rcv_cnt + 4'd1;
               if (rcv_last) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         iss_cnt  <= '0;
         rcv_cnt  <= '0;
         blk_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         iss_cnt  <= iss_nxt;
         rcv_cnt  <= rcv_nxt;
         blk_done <= done_nxt;
      end
   end

   // Buffer contents are only meaningful after a full row pass, so no reset is needed.
   always_ff @(posedge clk) begin
      if (state == ROW && dct_out_valid)
         for (int c = 0; c < 8; c++) tbuf[rcv_cnt[2:0]][c] <= dct_out_data[c*DATA_W +: DATA_W];
   end

   a_idle_no_result: assert property (@(posedge clk) disable iff (!rst_n)
      !(state == IDLE && dct_out_valid));
   a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
      iss_cnt <= 4'd8 && rcv_cnt <= 4'd8);

endmodule
